rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 130 +++++++++++++
 tb/tb_rr_arbiter_8.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter.
// One owner at a time holds the grant until it signals done, drops its
// request, or uses up MAX_HOLD consecutive cycles. One idle cycle always
// separates two grants, and the next search starts just above the last owner.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Hold-counter value seen in the last permitted cycle of one grant.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] last_idx_q, last_idx_d;

    logic [2:0] winner_idx;
    logic       owner_req;
    logic       hold_expired;
    logic       release_now;

    // Round-robin pick: first set request bit scanning up from last_idx+1.
    always_comb begin
        winner_idx = last_idx_q + 3'd1;
        // Walk from the lowest priority (offset 8 = last owner) to the
        // highest (offset 1); the final match is the winner.
        for (int i = 8; i >= 1; i--) begin
            if (req[3'(last_idx_q + 3'(i))]) begin
                winner_idx = 3'(last_idx_q + 3'(i));
            end
        end
    end

    // Release conditions evaluated for the current owner.
    always_comb begin
        owner_req    = req[grant_idx_q];
        hold_expired = (hold_q == HOLD_LAST);
        release_now  = done || !owner_req || hold_expired;
    end

    // Next-state and registered-output logic of the IDLE/GRANT machine.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        hold_d        = hold_q;
        last_idx_d    = last_idx_q;

        case (state_q)
            IDLE: begin
                grant_d       = 8'h00;
                grant_valid_d = 1'b0;
                if (|req) begin
                    state_d       = GRANT;
                    grant_idx_d   = winner_idx;
                    grant_d       = 8'h01 << winner_idx;
                    grant_valid_d = 1'b1;
                    last_idx_d    = winner_idx;
                    hold_d        = 8'h00;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d       = IDLE;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                    // Only a pure hold-limit revocation counts as a timeout.
                    timeout_d     = hold_expired && !done && owner_req;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'h01;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = 8'h00;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= 8'h00;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_q        <= 8'h00;
            last_idx_q    <= 3'd7;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_q        <= hold_d;
            last_idx_q    <= last_idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed bench for rr_arbiter_8 (MAX_HOLD = 15).
// Each step drives req/done, queues the outputs expected after the next
// rising edge, then pops and compares them 1 time unit after that edge.
module tb_rr_arbiter_8;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(15)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       chk_idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_field(input string tag, input string field,
                               input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] g, input logic [2:0] idx,
                            input logic chk_idx, input logic v, input logic to);
        exp_t e;
        e.tag = tag; e.grant = g; e.idx = idx; e.chk_idx = chk_idx; e.valid = v; e.to = to;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty observed=0 expected=1 entries");
        end else begin
            e = sb.pop_front();
            check_field(e.tag, "grant", grant, e.grant);
            check_field(e.tag, "grant_valid", {7'd0, grant_valid}, {7'd0, e.valid});
            check_field(e.tag, "timeout", {7'd0, timeout}, {7'd0, e.to});
            if (e.chk_idx) check_field(e.tag, "grant_idx", {5'd0, grant_idx}, {5'd0, e.idx});
        end
    endtask

    // Drive inputs, clock once, compare against the queued expectation.
    task automatic step(input logic [7:0] r, input logic d, input string tag,
                        input logic [7:0] g, input logic [2:0] idx, input logic chk_idx,
                        input logic v, input logic to);
        req  = r;
        done = d;
        push_exp(tag, g, idx, chk_idx, v, to);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic grant_step(input logic [7:0] r, input logic d, input string tag,
                              input logic [2:0] idx);
        step(r, d, tag, 8'h01 << idx, idx, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle_step(input logic [7:0] r, input logic d, input string tag,
                             input logic to);
        step(r, d, tag, 8'h00, 3'd0, 1'b0, 1'b0, to);
    endtask

    initial begin
        req     = 8'h00;
        done    = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        push_exp("reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        pop_compare();

        // Arbitration starts on the first edge after release; latency 1.
        @(negedge clk);
        reset_n = 1'b1;
        grant_step(8'h01, 1'b0, "first_grant", 3'd0);
        idle_step (8'h01, 1'b1, "done_release", 1'b0);

        // done in IDLE is ignored: it neither blocks a grant nor keeps IDLE.
        idle_step (8'h00, 1'b1, "idle_done_noreq", 1'b0);
        grant_step(8'h01, 1'b1, "idle_done_grant", 3'd0);
        idle_step (8'h00, 1'b0, "req_drop_0", 1'b0);

        // Owner 5 holds against other requests, then drops; wrap 6,7,0,1,2.
        grant_step(8'h20, 1'b0, "own5", 3'd5);
        grant_step(8'h24, 1'b0, "own5_hold", 3'd5);
        idle_step (8'h04, 1'b0, "own5_drop", 1'b0);
        grant_step(8'h04, 1'b0, "wrap_to_2", 3'd2);
        idle_step (8'h00, 1'b0, "req_drop_2", 1'b0);

        // Requester 3 never releases: 15 grant cycles, then timeout pulse.
        grant_step(8'h08, 1'b0, "hold3_c1", 3'd3);
        for (int c = 2; c <= 15; c++) grant_step(8'h08, 1'b0, "hold3_cN", 3'd3);
        idle_step (8'h08, 1'b0, "hold3_timeout", 1'b1);
        grant_step(8'h08, 1'b0, "hold3_regrant", 3'd3);
        idle_step (8'h00, 1'b0, "req_drop_3", 1'b0);

        // done coincides with the hold limit: single exit, no timeout.
        grant_step(8'h10, 1'b0, "hold4_c1", 3'd4);
        for (int c = 2; c <= 15; c++) grant_step(8'h10, 1'b0, "hold4_cN", 3'd4);
        idle_step (8'h10, 1'b1, "done_and_limit", 1'b0);
        idle_step (8'h00, 1'b0, "after_done_limit", 1'b0);

        // Asynchronous reset in the middle of a grant cycle.
        grant_step(8'h40, 1'b0, "own6", 3'd6);
        #2 reset_n = 1'b0;
        #1;
        push_exp("async_reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        pop_compare();
        @(negedge clk);
        reset_n = 1'b1;
        grant_step(8'h81, 1'b0, "post_reset_pick0", 3'd0);
        idle_step (8'h81, 1'b1, "post_reset_done", 1'b0);

        // Fresh reset, then all requesting with done after each grant.
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            grant_step(8'hFF, 1'b0, "rr_all", 3'(k % 8));
            idle_step (8'hFF, 1'b1, "rr_gap", 1'b0);
        end
        idle_step(8'h00, 1'b0, "final_idle", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
